// File: rtl/uart_baud_gen_frac_if.sv
// ---------------------------------------------------------------------------
// uart_baud_gen_frac_if
//
// Bundles the control inputs and tick outputs of the fractional baud-rate
// generator so the transmitter, receiver and bench can share one connection.
//
// Signals:
//   enable        count enable; low freezes all generator state
//   restart       synchronous re-alignment of the bit phase (start-bit detect)
//   divide_int    integer divisor N
//   divide_frac   fractional divisor F, in units of 2^-FRAC_BITS
//   sample_tick   one-cycle pulse per sample period
//   baud_tick     one-cycle pulse per bit
//   mid_tick      one-cycle pulse at bit centre
//   sample_index  current sample position within the bit
//
// There is no handshake on this bundle: the divisor and control inputs are
// level signals sampled on every clock edge, and the ticks are single-cycle
// strobes that the consumer must act on in the cycle they are high.
//
// Modports:
//   master  the user of the ticks (drives control, receives ticks)
//   slave   the generator itself
// ---------------------------------------------------------------------------
interface uart_baud_gen_frac_if #(
    parameter int WIDTH      = 16,
    parameter int FRAC_BITS  = 4,
    parameter int OVERSAMPLE = 16
);
    localparam int IDX_W = $clog2(OVERSAMPLE);

    logic                 enable;
    logic                 restart;
    logic [WIDTH-1:0]     divide_int;
    logic [FRAC_BITS-1:0] divide_frac;
    logic                 sample_tick;
    logic                 baud_tick;
    logic                 mid_tick;
    logic [IDX_W-1:0]     sample_index;

    modport master (
        output enable,
        output restart,
        output divide_int,
        output divide_frac,
        input  sample_tick,
        input  baud_tick,
        input  mid_tick,
        input  sample_index
    );

    modport slave (
        input  enable,
        input  restart,
        input  divide_int,
        input  divide_frac,
        output sample_tick,
        output baud_tick,
        output mid_tick,
        output sample_index
    );
endinterface

// File: rtl/uart_baud_gen_frac.sv
// ---------------------------------------------------------------------------
// uart_baud_gen_frac
//
// Fractional baud-rate and oversampling tick generator. One programmable
// divisor (integer part N, fractional part F) sets the sample period to an
// average of N + 1 + F/2^FRAC_BITS clock cycles. Every OVERSAMPLE sample
// ticks form one bit: baud_tick marks the bit boundary and mid_tick the bit
// centre. restart re-aligns the bit phase to zero.
//
// Ports:
//   clk    clock, all state changes on the rising edge
//   reset  asynchronous active-low reset (0 = in reset)
//   bus    slave side of uart_baud_gen_frac_if (control in, ticks out)
//
// All outputs are registered; a tick is high for exactly the cycle after the
// terminal edge that produced it.
// ---------------------------------------------------------------------------
module uart_baud_gen_frac #(
    parameter int WIDTH      = 16,
    parameter int FRAC_BITS  = 4,
    parameter int OVERSAMPLE = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    uart_baud_gen_frac_if.slave   bus
);
    localparam int IDX_W = $clog2(OVERSAMPLE);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_BEFORE_MID = IDX_W'(OVERSAMPLE / 2 - 1);

    logic [WIDTH-1:0]     count_q, count_d;
    logic [FRAC_BITS-1:0] acc_q, acc_d;
    logic                 e_q, e_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 sample_tick_q, sample_tick_d;
    logic                 baud_tick_q, baud_tick_d;
    logic                 mid_tick_q, mid_tick_d;

    // Terminal limit needs one extra bit so N = 2^WIDTH-1 plus the stretch
    // flag does not wrap to a small value.
    logic [WIDTH:0]       limit;
    logic                 terminal;
    logic [FRAC_BITS:0]   acc_sum;

    always_comb begin
        limit    = {1'b0, bus.divide_int} + {{WIDTH{1'b0}}, e_q};
        // >= rather than == so a divisor lowered below the running count
        // terminates at once instead of wrapping through 2^WIDTH.
        terminal = ({1'b0, count_q} >= limit);
        acc_sum  = {1'b0, acc_q} + {1'b0, bus.divide_frac};
    end

    always_comb begin
        count_d       = count_q;
        acc_d         = acc_q;
        e_d           = e_q;
        idx_d         = idx_q;
        sample_tick_d = 1'b0;
        baud_tick_d   = 1'b0;
        mid_tick_d    = 1'b0;

        if (bus.restart) begin
            count_d = '0;
            acc_d   = '0;
            e_d     = 1'b0;
            idx_d   = '0;
        end else if (bus.enable) begin
            if (terminal) begin
                count_d       = '0;
                sample_tick_d = 1'b1;
                // The carry out of the phase accumulator stretches the next
                // sample period by one cycle; this spreads the F long periods
                // evenly over every 2^FRAC_BITS periods.
                acc_d         = acc_sum[FRAC_BITS-1:0];
                e_d           = acc_sum[FRAC_BITS];
                idx_d         = idx_q + IDX_W'(1);
                baud_tick_d   = (idx_q == IDX_LAST);
                mid_tick_d    = (idx_q == IDX_BEFORE_MID);
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q       <= '0;
            acc_q         <= '0;
            e_q           <= 1'b0;
            idx_q         <= '0;
            sample_tick_q <= 1'b0;
            baud_tick_q   <= 1'b0;
            mid_tick_q    <= 1'b0;
        end else begin
            count_q       <= count_d;
            acc_q         <= acc_d;
            e_q           <= e_d;
            idx_q         <= idx_d;
            sample_tick_q <= sample_tick_d;
            baud_tick_q   <= baud_tick_d;
            mid_tick_q    <= mid_tick_d;
        end
    end

    assign bus.sample_tick  = sample_tick_q;
    assign bus.baud_tick    = baud_tick_q;
    assign bus.mid_tick     = mid_tick_q;
    assign bus.sample_index = idx_q;
endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// ---------------------------------------------------------------------------
// tb_uart_baud_gen_frac
//
// Directed bench for uart_baud_gen_frac with WIDTH=16, FRAC_BITS=4,
// OVERSAMPLE=16. Inputs are driven and outputs observed 1 time unit after
// each rising edge.
// ---------------------------------------------------------------------------
module tb_uart_baud_gen_frac;
    localparam int WIDTH      = 16;
    localparam int FRAC_BITS  = 4;
    localparam int OVERSAMPLE = 16;
    localparam int IDX_W      = $clog2(OVERSAMPLE);

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    uart_baud_gen_frac_if #(
        .WIDTH(WIDTH), .FRAC_BITS(FRAC_BITS), .OVERSAMPLE(OVERSAMPLE)
    ) u_if ();

    uart_baud_gen_frac #(
        .WIDTH(WIDTH), .FRAC_BITS(FRAC_BITS), .OVERSAMPLE(OVERSAMPLE)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT out of reset with enable high; the next rising edge is
    // enabled edge 1.
    task automatic apply_reset(input int n, input int f);
        reset            = 1'b0;
        u_if.enable      = 1'b0;
        u_if.restart     = 1'b0;
        u_if.divide_int  = WIDTH'(n);
        u_if.divide_frac = FRAC_BITS'(f);
        step();
        step();
        reset       = 1'b1;
        u_if.enable = 1'b1;
    endtask

    // Steps until sample_tick is seen or the budget runs out.
    task automatic wait_tick(input int budget, output int cycles, output bit seen);
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < budget) begin
            step();
            cycles++;
            if (u_if.sample_tick === 1'b1) seen = 1'b1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset            = 1'b0;
        u_if.enable      = 1'b1;
        u_if.restart     = 1'b0;
        u_if.divide_int  = '0;
        u_if.divide_frac = '0;
        step();
        step();
        checks++;
        if (u_if.sample_tick !== 1'b0) begin
            errors++; $display("FAIL reset_sample_tick: got %b expected 0", u_if.sample_tick);
        end
        checks++;
        if (u_if.baud_tick !== 1'b0) begin
            errors++; $display("FAIL reset_baud_tick: got %b expected 0", u_if.baud_tick);
        end
        checks++;
        if (u_if.mid_tick !== 1'b0) begin
            errors++; $display("FAIL reset_mid_tick: got %b expected 0", u_if.mid_tick);
        end
        checks++;
        if (u_if.sample_index !== '0) begin
            errors++; $display("FAIL reset_sample_index: got %0d expected 0", u_if.sample_index);
        end
    endtask

    // N=3, F=0: tick every 4 edges, mid on edge 32, baud on edge 64, repeat.
    task automatic test_integer_divide();
        logic             exp_tick, exp_mid, exp_baud;
        logic [IDX_W-1:0] exp_idx;
        apply_reset(3, 0);
        for (int e = 1; e <= 128; e++) begin
            step();
            exp_tick = (e % 4 == 0);
            exp_mid  = (e % 64 == 32);
            exp_baud = (e % 64 == 0);
            exp_idx  = IDX_W'((e / 4) % 16);
            checks++;
            if (u_if.sample_tick !== exp_tick) begin
                errors++; $display("FAIL int_sample_tick edge %0d: got %b expected %b", e, u_if.sample_tick, exp_tick);
            end
            checks++;
            if (u_if.mid_tick !== exp_mid) begin
                errors++; $display("FAIL int_mid_tick edge %0d: got %b expected %b", e, u_if.mid_tick, exp_mid);
            end
            checks++;
            if (u_if.baud_tick !== exp_baud) begin
                errors++; $display("FAIL int_baud_tick edge %0d: got %b expected %b", e, u_if.baud_tick, exp_baud);
            end
            checks++;
            if (u_if.sample_index !== exp_idx) begin
                errors++; $display("FAIL int_sample_index edge %0d: got %0d expected %0d", e, u_if.sample_index, exp_idx);
            end
        end
    endtask

    // N=2, F=4: accumulator 4,8,12,0(carry) -> every 4th period is 4 cycles.
    task automatic test_fractional();
        int cycles;
        bit seen;
        int exp_len;
        int total;
        apply_reset(2, 4);
        wait_tick(30, cycles, seen);
        checks++;
        if (!seen || cycles != 3) begin
            errors++; $display("FAIL frac_first_tick: got %0d cycles (seen %0d) expected 3", cycles, seen);
        end
        total = 0;
        for (int i = 0; i < 16; i++) begin
            // Period k = i+2 counted from reset; periods 5,9,13,17 are long.
            exp_len = (((i + 2) % 4) == 1) ? 4 : 3;
            wait_tick(30, cycles, seen);
            total += cycles;
            checks++;
            if (!seen || cycles != exp_len) begin
                errors++; $display("FAIL frac_period %0d: got %0d cycles (seen %0d) expected %0d", i, cycles, seen, exp_len);
            end
        end
        checks++;
        if (total != 52) begin
            errors++; $display("FAIL frac_total: got %0d cycles expected 52", total);
        end
    endtask

    // N=9: restart at sample_index=5, count=4.
    task automatic test_restart();
        int cycles;
        bit seen;
        apply_reset(9, 0);
        for (int t = 1; t <= 5; t++) begin
            wait_tick(30, cycles, seen);
            checks++;
            if (!seen || cycles != 10) begin
                errors++; $display("FAIL restart_pre_tick %0d: got %0d cycles (seen %0d) expected 10", t, cycles, seen);
            end
        end
        checks++;
        if (u_if.sample_index !== IDX_W'(5)) begin
            errors++; $display("FAIL restart_pre_index: got %0d expected 5", u_if.sample_index);
        end
        repeat (4) step();
        u_if.restart = 1'b1;
        step();
        u_if.restart = 1'b0;
        checks++;
        if (u_if.sample_tick !== 1'b0 || u_if.mid_tick !== 1'b0 || u_if.baud_tick !== 1'b0) begin
            errors++; $display("FAIL restart_ticks: got %b%b%b expected 000", u_if.sample_tick, u_if.mid_tick, u_if.baud_tick);
        end
        checks++;
        if (u_if.sample_index !== '0) begin
            errors++; $display("FAIL restart_index: got %0d expected 0", u_if.sample_index);
        end
        wait_tick(30, cycles, seen);
        checks++;
        if (!seen || cycles != 10) begin
            errors++; $display("FAIL restart_first_tick: got %0d cycles (seen %0d) expected 10", cycles, seen);
        end
        checks++;
        if (u_if.sample_index !== IDX_W'(1)) begin
            errors++; $display("FAIL restart_first_index: got %0d expected 1", u_if.sample_index);
        end
        for (int t = 2; t <= 8; t++) begin
            wait_tick(30, cycles, seen);
            checks++;
            if (!seen || u_if.mid_tick !== (t == 8)) begin
                errors++; $display("FAIL restart_mid tick %0d: got mid %b (seen %0d) expected %0d", t, u_if.mid_tick, seen, (t == 8));
            end
        end
    endtask

    // N=100, count=50, then N=5: terminate next edge, then 6-cycle period.
    task automatic test_divisor_change();
        int cycles;
        bit seen;
        apply_reset(100, 0);
        repeat (50) step();
        checks++;
        if (u_if.sample_tick !== 1'b0) begin
            errors++; $display("FAIL divchg_before: got %b expected 0", u_if.sample_tick);
        end
        u_if.divide_int = WIDTH'(5);
        step();
        checks++;
        if (u_if.sample_tick !== 1'b1) begin
            errors++; $display("FAIL divchg_immediate: got %b expected 1", u_if.sample_tick);
        end
        wait_tick(30, cycles, seen);
        checks++;
        if (!seen || cycles != 6) begin
            errors++; $display("FAIL divchg_period: got %0d cycles (seen %0d) expected 6", cycles, seen);
        end
    endtask

    // N=3: freeze right after a tick, then again mid-period.
    task automatic test_enable_hold();
        int cycles;
        bit seen;
        apply_reset(3, 0);
        repeat (4) step();
        checks++;
        if (u_if.sample_tick !== 1'b1) begin
            errors++; $display("FAIL hold_first_tick: got %b expected 1", u_if.sample_tick);
        end
        u_if.enable = 1'b0;
        for (int c = 0; c < 7; c++) begin
            step();
            checks++;
            if (u_if.sample_tick !== 1'b0 || u_if.sample_index !== IDX_W'(1)) begin
                errors++; $display("FAIL hold_a cycle %0d: got tick %b index %0d expected tick 0 index 1", c, u_if.sample_tick, u_if.sample_index);
            end
        end
        u_if.enable = 1'b1;
        wait_tick(30, cycles, seen);
        checks++;
        if (!seen || cycles != 4) begin
            errors++; $display("FAIL hold_a_resume: got %0d cycles (seen %0d) expected 4", cycles, seen);
        end
        repeat (2) step();
        u_if.enable = 1'b0;
        for (int c = 0; c < 7; c++) begin
            step();
            checks++;
            if (u_if.sample_tick !== 1'b0 || u_if.sample_index !== IDX_W'(2)) begin
                errors++; $display("FAIL hold_b cycle %0d: got tick %b index %0d expected tick 0 index 2", c, u_if.sample_tick, u_if.sample_index);
            end
        end
        u_if.enable = 1'b1;
        wait_tick(30, cycles, seen);
        checks++;
        if (!seen || cycles != 2) begin
            errors++; $display("FAIL hold_b_resume: got %0d cycles (seen %0d) expected 2", cycles, seen);
        end
        checks++;
        if (u_if.sample_index !== IDX_W'(3)) begin
            errors++; $display("FAIL hold_b_index: got %0d expected 3", u_if.sample_index);
        end
    endtask

    // N=0, F=0: tick every cycle; async reset between edges while ticks high.
    task automatic test_async_reset();
        logic [IDX_W-1:0] exp_idx;
        apply_reset(0, 0);
        repeat (8) step();
        checks++;
        if (u_if.sample_tick !== 1'b1 || u_if.mid_tick !== 1'b1 || u_if.sample_index !== IDX_W'(8)) begin
            errors++; $display("FAIL async_pre: got tick %b mid %b index %0d expected 1 1 8", u_if.sample_tick, u_if.mid_tick, u_if.sample_index);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (u_if.sample_tick !== 1'b0 || u_if.mid_tick !== 1'b0 || u_if.baud_tick !== 1'b0 || u_if.sample_index !== '0) begin
            errors++; $display("FAIL async_clear: got tick %b mid %b baud %b index %0d expected all 0", u_if.sample_tick, u_if.mid_tick, u_if.baud_tick, u_if.sample_index);
        end
        step();
        checks++;
        if (u_if.sample_tick !== 1'b0) begin
            errors++; $display("FAIL async_held: got %b expected 0", u_if.sample_tick);
        end
        reset = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            step();
            exp_idx = IDX_W'(e % 16);
            checks++;
            if (u_if.sample_tick !== 1'b1 || u_if.sample_index !== exp_idx ||
                u_if.baud_tick !== (e == 16) || u_if.mid_tick !== (e == 8)) begin
                errors++; $display("FAIL async_after edge %0d: got tick %b idx %0d baud %b mid %b expected 1 %0d %0d %0d",
                                   e, u_if.sample_tick, u_if.sample_index, u_if.baud_tick, u_if.mid_tick, exp_idx, (e == 16), (e == 8));
            end
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_integer_divide();
        test_fractional();
        test_restart();
        test_divisor_change();
        test_enable_hold();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_baud_gen_frac.md
# uart_baud_gen_frac

Parametrised fractional baud-rate and oversampling tick generator for the UART. It generates a sample tick at the oversampling rate, a baud tick once per bit, and a mid-bit tick from one programmable divisor. The divisor has an integer part and a fractional part, so the average rate can be set finer than whole clock cycles. The block feeds both the UART transmitter (baud tick) and the receiver (sample/mid-bit ticks, re-aligned by `restart` on start-bit detection).

## Interface
- `WIDTH`, 16, width of integer divisor and period counter
- `FRAC_BITS`, 4, width of fractional divisor and phase accumulator (≥1)
- `OVERSAMPLE`, 16, sample ticks per bit; power of two, ≥2
- `clk`  input  1  clock; all state changes on rising edge
- `reset`  input  1  asynchronous, active-low reset (0 = in reset)
- `enable`  input  1  count enable; low freezes all state
- `restart`  input  1  synchronous re-alignment of bit phase
- `divide_int`  input  WIDTH  integer divisor N
- `divide_frac`  input  FRAC_BITS  fractional divisor F (units of 2^-FRAC_BITS)
- `sample_tick`  output  1  one-cycle pulse per sample period
- `baud_tick`  output  1  one-cycle pulse per bit (every OVERSAMPLE sample ticks)
- `mid_tick`  output  1  one-cycle pulse at bit centre
- `sample_index`  output  log2(OVERSAMPLE)  current sample position within bit

## Operation
- State: period counter `count` (WIDTH), phase accumulator `acc` (FRAC_BITS), stretch flag `e` (1 bit), `sample_index`. All outputs are registered.
- Reset (`reset`=0, asynchronous): count, acc, e, sample_index and all tick outputs go to 0 immediately.
- Priority order per edge: reset, then `restart`, then `enable`.
- `restart`=1: clears count, acc, e, and sample_index. All ticks are 0 on the next cycle. `enable` is ignored on that edge.
- `enable`=0 (no restart): all state is held. Tick outputs are driven 0 on the next cycle.
- `enable`=1: the terminal limit is L = N + e, computed in WIDTH+1 bits (no overflow at N = 2^WIDTH−1).
  - If count ≥ L (terminal): count←0, sample_tick←1, {carry, acc}←acc + F, e←carry, sample_index←sample_index+1 (mod OVERSAMPLE).
  - Otherwise: count←count+1, sample_tick←0.
- Average sample period is N + 1 + F/2^FRAC_BITS cycles. Over any 2^FRAC_BITS consecutive sample periods, exactly F of them are one cycle longer.
- baud_tick←1 on the terminal edge where sample_index wraps OVERSAMPLE−1→0.
- mid_tick←1 on the terminal edge where sample_index goes OVERSAMPLE/2−1→OVERSAMPLE/2.
- The ≥ compare is mandatory. If `divide_int` is reduced below the current count on the fly, the next enabled edge terminates; no wrap through 2^WIDTH is allowed.
- Divisor inputs are sampled every edge. They take effect immediately and need no handshake.

## Timing
- Latency: the terminal edge sets the tick, and the tick is high for exactly the following cycle.
- With `enable` held high from reset release and e=0, the first sample_tick is high after enabled edge N+1. Subsequent ticks are N+1 cycles apart.
- N=0, F=0: sample_tick is high every cycle, baud_tick every OVERSAMPLE cycles.
- baud_tick and mid_tick always coincide with a sample_tick and are never asserted together.
- `sample_index` updates on the same edge as the tick, so it reads the new value while the tick is high.
- Reset asserted mid-period: outputs are 0 asynchronously. After release, counting restarts from zero phase.

## Test plan
- N=3, F=0, OVERSAMPLE=16, enable high after reset → sample_tick every 4 cycles (first after edge 4), mid_tick on the 8th sample tick (edge 32), baud_tick on the 16th (edge 64), then every 64 cycles.
- N=2, F=4, FRAC_BITS=4 → 16 consecutive sample periods total exactly 52 cycles: twelve 3-cycle and four 4-cycle periods, each long period preceded by three short ones.
- Run N=9. Pulse `restart` when sample_index=5 and count=4 → no tick next cycle. Next sample_tick comes 10 cycles after the restart edge with sample_index=1. mid_tick arrives on the 8th tick after restart.
- N=100 and count=50, change `divide_int` to 5 → sample_tick on the next enabled edge. The following period is 6 cycles.
- Drop `enable` for 7 cycles mid-period with N=3 → count and sample_index frozen and ticks 0. Tick spacing resumes with the remaining count intact.
- Assert `reset` low asynchronously between edges while sample_tick=1 → sample_tick, baud_tick, mid_tick and sample_index go 0 before the next edge. N=0, F=0 after release → sample_tick high every cycle.
